// File: rtl/dct_nios_cpu_div_pkg.sv
// Shared types and constants for the Nios II gen2 iterative divide cell.
package dct_nios_cpu_div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    ITER,
    FIX
  } div_state_e;

  // Width of an iteration counter that must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/dct_nios_cpu_div_clz.sv
// Combinational leading-zero count; an all-zero input yields WIDTH.
module dct_nios_cpu_div_clz
  import dct_nios_cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0]               val,
  output logic [cnt_width(WIDTH)-1:0]    lz
);

  localparam int CW = cnt_width(WIDTH);

  logic found;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (val[i]) begin
          found = 1'b1;
        end else begin
          lz = lz + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/dct_nios_cpu_div_cell.sv
// Radix-2 restoring DIV/DIVU cell: done WIDTH+2 cycles after start (2 on divide-by-zero); starts while busy are dropped.
// DCT_NIOS_DIV_EARLY_OUT_EN skips the dividend magnitude's leading zeros, shortening latency to WIDTH-z+2.
module dct_nios_cpu_div_cell
  import dct_nios_cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  input  logic             div_start,
  input  logic             div_signed,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] div_quot,
  output logic [WIDTH-1:0] div_rem,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state, state_nxt;
  logic [WIDTH-1:0] src1_q, src2_q;
  logic             sgn_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] q_sr;
  logic [WIDTH-1:0] rem_sr;
  logic             quot_neg, rem_neg, dz_q;
  logic [CW-1:0]    cnt;

  logic             a_neg, b_neg, a_zero;
  logic [WIDTH-1:0] a_mag, b_mag, a_pre;
  logic [CW-1:0]    cnt_init;
  logic [WIDTH:0]   rem_shl, trial;

  assign a_neg = sgn_q & src1_q[WIDTH-1];
  assign b_neg = sgn_q & src2_q[WIDTH-1];
  assign a_mag = a_neg ? -src1_q : src1_q;
  assign b_mag = b_neg ? -src2_q : src2_q;

`ifdef DCT_NIOS_DIV_EARLY_OUT_EN
  logic [CW-1:0] lz;

  dct_nios_cpu_div_clz #(.WIDTH(WIDTH)) u_clz (
    .val (a_mag),
    .lz  (lz)
  );

  assign a_pre    = a_mag << lz;
  assign cnt_init = CW'(WIDTH) - lz;
  assign a_zero   = (a_mag == '0);
`else
  assign a_pre    = a_mag;
  assign cnt_init = CW'(WIDTH);
  assign a_zero   = 1'b0;
`endif

  // One extra bit on the shifted remainder keeps the trial subtract's borrow.
  assign rem_shl = {rem_sr, q_sr[WIDTH-1]};
  assign trial   = rem_shl - {1'b0, dvs_q};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (div_start) state_nxt = PREP;
      PREP:    state_nxt = (b_mag == '0 || a_zero) ? FIX : ITER;
      ITER:    if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign div_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      src1_q      <= '0;
      src2_q      <= '0;
      sgn_q       <= 1'b0;
      dvs_q       <= '0;
      q_sr        <= '0;
      rem_sr      <= '0;
      quot_neg    <= 1'b0;
      rem_neg     <= 1'b0;
      dz_q        <= 1'b0;
      cnt         <= '0;
      div_done    <= 1'b0;
      div_quot    <= '0;
      div_rem     <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_done <= 1'b0;
      case (state)
        IDLE: begin
          if (div_start) begin
            src1_q <= E_src1;
            src2_q <= E_src2;
            sgn_q  <= div_signed;
          end
        end
        PREP: begin
          quot_neg <= a_neg ^ b_neg;
          rem_neg  <= a_neg;
          dz_q     <= (b_mag == '0);
          dvs_q    <= b_mag;
          q_sr     <= a_pre;
          rem_sr   <= '0;
          cnt      <= cnt_init;
        end
        ITER: begin
          // Quotient bits shift in at the bottom as dividend bits leave the top.
          if (!trial[WIDTH]) begin
            rem_sr <= trial[WIDTH-1:0];
            q_sr   <= {q_sr[WIDTH-2:0], 1'b1};
          end else begin
            rem_sr <= rem_shl[WIDTH-1:0];
            q_sr   <= {q_sr[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          div_done    <= 1'b1;
          div_by_zero <= dz_q;
          if (dz_q) begin
            div_quot <= '1;
            div_rem  <= src1_q;
          end else begin
            div_quot <= quot_neg ? -q_sr : q_sr;
            div_rem  <= rem_neg ? -rem_sr : rem_sr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
